ppc_ebi_slave: RTL and testbench
================================

# ppc_ebi_slave

Parametrised, clock-synchronous PowerPC external-bus (EBI) slave front end. It samples the asynchronous chip-select, output-enable, write-enable, read/write, address and data pins through a configurable synchronizer. It qualifies each bus cycle with a glitch filter and emits exactly one registered read or write strobe per chip-select assertion, with latched address, byte enables, write data and chip-select index. It sits between the PPC EBI pins and the internal register/memory fabric, and drives read data back onto the bus.

## Interface
Parameters:
- `EBI_AW`, 24, width of `ebi_addr` (PPC A31..A8 by default)
- `ADDR_LSB`, 2, number of low `ebi_addr` bits dropped; `addr_o` width is `EBI_AW-ADDR_LSB`
- `NCS`, 1, number of chip-select inputs, ≥1
- `BE_W`, 4, byte-lane count (width of `we_n`)
- `DW`, 32, data width, equal to `8*BE_W`
- `SYNC_STAGES`, 2, flop stages per synchronized input, ≥2

Ports:
- `clk`  in  1  single system clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `cs_n`  in  NCS  chip selects, active low, asynchronous
- `oe_n`  in  1  output enable, active low, asynchronous
- `we_n`  in  BE_W  per-byte write enables, active low
- `rd_wr`  in  1  1 = read, 0 = write
- `ebi_addr`  in  EBI_AW  bus address
- `ebi_data_i`  in  DW  write data from bus
- `ebi_data_o`  out  DW  read data to bus
- `ebi_data_oe`  out  1  bus data driver enable
- `addr_o`  out  EBI_AW-ADDR_LSB  latched `ebi_addr[EBI_AW-1:ADDR_LSB]`
- `cs_idx_o`  out  $clog2(NCS) (min 1)  latched index of the active chip select
- `be_o`  out  BE_W  latched `~we_n`; all ones for reads
- `wdata_o`  out  DW  latched write data
- `re_o`  out  1  one-cycle read strobe
- `we_o`  out  1  one-cycle write strobe
- `rd_data_i`  in  DW  read data, valid the cycle after `re_o`

## Operation
- All pin inputs pass through `SYNC_STAGES` flops. Decode uses only the synchronized copies (suffix `_s`).
- `cs_any` = any bit of `cs_n_s` low. Active index = lowest-numbered low bit.
- Write condition `wc` = `~rd_wr_s & cs_any & (we_n_s != all ones)`.
- Read condition `rc` = `rd_wr_s & cs_any & (we_n_s == all ones)`. `oe_n` is synchronized and ignored for decode.
- FSM states: IDLE, QUAL, ACCESS, HOLD.
  - IDLE → QUAL when `wc | rc`. The type, address, index, byte enables and data are captured into shadow registers.
  - QUAL → ACCESS when the same condition, address and index still hold. Otherwise QUAL → IDLE with no strobe (glitch reject).
  - ACCESS → HOLD unconditionally.
  - HOLD → IDLE when `cs_any` = 0.
- Output registers `addr_o`, `cs_idx_o`, `be_o` and `wdata_o` load from the shadow registers on entry to ACCESS. They hold their values until the next ACCESS.
- `we_o` is high only in ACCESS for a write. `re_o` is high only in ACCESS for a read.
- Read return: on the edge after ACCESS (read), `ebi_data_o` ← `rd_data_i` and `ebi_data_oe` ← 1. `ebi_data_oe` stays high through HOLD and clears on the HOLD→IDLE transition.
- A type, address or we_n change during HOLD is ignored. Chip select must deassert before the next access, so there is one strobe per CS assertion.
- Reset: state = IDLE. All outputs are 0, including `ebi_data_oe`, `re_o` and `we_o`. Synchronizer flops reset to the inactive level: `cs_n`, `oe_n` and `we_n` to 1, others to 0.
- Reset asserted mid-access aborts with no strobe. After reset, a chip select still low must first be seen high before any new strobe (IDLE requires `cs_any`=0 once; tracked by an `armed` flag cleared by reset).

## Timing
- Pins stable before edge k → synchronized after edge k+SYNC_STAGES−1 → QUAL after edge k+SYNC_STAGES → ACCESS (strobe high) for exactly one cycle after edge k+SYNC_STAGES+1.
- With SYNC_STAGES=2, strobe latency is 3 edges from pin sample.
- `rd_data_i` is sampled at the edge ending ACCESS. `ebi_data_oe` rises on that same edge, i.e. 4 edges after the pin sample at SYNC_STAGES=2.
- `ebi_data_oe` falls SYNC_STAGES+1 edges after `cs_n` returns high.
- The bus cycle must hold CS for ≥ SYNC_STAGES+3 clocks for a read to be serviced.

## Structure
- Package `ppc_ebi_pkg`: FSM state enum (IDLE, QUAL, ACCESS, HOLD), access-type enum (RD, WR), default parameter constants.
- Sub-module `ppc_ebi_sync`: generic N-stage, W-bit synchronizer with a per-bit reset value. It is instantiated once per pin group.

## Test plan
- Write, NCS=1: `ebi_addr`=0x123454, `we_n`=4'b0000, `rd_wr`=0, `ebi_data_i`=0xDEADBEEF, CS held 8 clocks → `we_o` high exactly 1 cycle at edge 3, `addr_o`=0x048D15, `be_o`=4'hF, `wdata_o`=0xDEADBEEF; `re_o` never high.
- Read: `rd_wr`=1, `we_n`=4'hF, `rd_data_i`=0xCAFEF00D → `re_o` 1 cycle, `ebi_data_o`=0xCAFEF00D with `oe`=1 from edge 4 until 3 edges after CS rises.
- Glitch: CS low for 1 clock only → no strobe, FSM returns to IDLE, `ebi_data_oe` stays 0.
- Byte write plus multi-CS, NCS=4: `cs_n`=4'b1001, `we_n`=4'b1101 → `cs_idx_o`=1, `be_o`=4'b0010; a long CS hold produces one strobe only.
- Reset mid-access: assert `rst` in QUAL with CS still low → no strobe. After release, no strobe until CS goes high then low again.
- Back-to-back: two writes separated by 1 clock of CS high → two strobes with distinct latched addresses.

Source files
------------

// File: rtl/ppc_ebi_pkg.sv
// Shared types and default parameters for the PowerPC EBI slave front end.
package ppc_ebi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACCESS,
        HOLD
    } state_t;

    typedef enum logic {
        RD,
        WR
    } acc_t;

    localparam int DEF_EBI_AW      = 24;
    localparam int DEF_ADDR_LSB    = 2;
    localparam int DEF_NCS         = 1;
    localparam int DEF_BE_W        = 4;
    localparam int DEF_DW          = 32;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/ppc_ebi_slave_if.sv
// Pin-side and fabric-side signal bundle of the EBI slave.
import ppc_ebi_pkg::*;

interface ppc_ebi_slave_if #(
    parameter int EBI_AW   = DEF_EBI_AW,
    parameter int ADDR_LSB = DEF_ADDR_LSB,
    parameter int NCS      = DEF_NCS,
    parameter int BE_W     = DEF_BE_W,
    parameter int DW       = DEF_DW
);
    localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;

    logic [NCS-1:0]             cs_n;
    logic                       oe_n;
    logic [BE_W-1:0]            we_n;
    logic                       rd_wr;
    logic [EBI_AW-1:0]          ebi_addr;
    logic [DW-1:0]              ebi_data_i;
    logic [DW-1:0]              ebi_data_o;
    logic                       ebi_data_oe;
    logic [EBI_AW-ADDR_LSB-1:0] addr_o;
    logic [CSW-1:0]             cs_idx_o;
    logic [BE_W-1:0]            be_o;
    logic [DW-1:0]              wdata_o;
    logic                       re_o;
    logic                       we_o;
    logic [DW-1:0]              rd_data_i;

    modport slave (
        input  cs_n, oe_n, we_n, rd_wr, ebi_addr, ebi_data_i, rd_data_i,
        output ebi_data_o, ebi_data_oe, addr_o, cs_idx_o, be_o, wdata_o, re_o, we_o
    );

    modport master (
        output cs_n, oe_n, we_n, rd_wr, ebi_addr, ebi_data_i, rd_data_i,
        input  ebi_data_o, ebi_data_oe, addr_o, cs_idx_o, be_o, wdata_o, re_o, we_o
    );

endinterface

// File: rtl/ppc_ebi_sync.sv
// Generic N-stage, W-bit synchronizer with a per-bit reset value.
module ppc_ebi_sync #(
    parameter int            W       = 1,
    parameter int            STAGES  = 2,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_pipe [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) r_pipe[i] <= RST_VAL;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/ppc_ebi_slave.sv
// EBI slave: synchronizes bus pins, glitch-qualifies each chip-select cycle and
// issues one read or write strobe per assertion with latched address/data.
import ppc_ebi_pkg::*;

module ppc_ebi_slave #(
    parameter int EBI_AW      = DEF_EBI_AW,
    parameter int ADDR_LSB    = DEF_ADDR_LSB,
    parameter int NCS         = DEF_NCS,
    parameter int BE_W        = DEF_BE_W,
    parameter int DW          = DEF_DW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    ppc_ebi_slave_if.slave  bus
);

    localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int OAW = EBI_AW - ADDR_LSB;

    logic [NCS-1:0]  w_csNS;
    logic            w_oeNS;
    logic [BE_W-1:0] w_weNS;
    logic            w_rdWrS;
    logic [OAW-1:0]  w_addrS;
    logic [DW-1:0]   w_dataS;
    logic            w_unusedOe;

    ppc_ebi_sync #(.W(NCS), .STAGES(SYNC_STAGES), .RST_VAL({NCS{1'b1}})) u_syncCs (
        .clk(clk), .rst(rst), .i_d(bus.cs_n), .o_q(w_csNS));
    ppc_ebi_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_syncOe (
        .clk(clk), .rst(rst), .i_d(bus.oe_n), .o_q(w_oeNS));
    ppc_ebi_sync #(.W(BE_W), .STAGES(SYNC_STAGES), .RST_VAL({BE_W{1'b1}})) u_syncWe (
        .clk(clk), .rst(rst), .i_d(bus.we_n), .o_q(w_weNS));
    ppc_ebi_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_syncRdWr (
        .clk(clk), .rst(rst), .i_d(bus.rd_wr), .o_q(w_rdWrS));
    ppc_ebi_sync #(.W(OAW), .STAGES(SYNC_STAGES), .RST_VAL({OAW{1'b0}})) u_syncAddr (
        .clk(clk), .rst(rst), .i_d(bus.ebi_addr[EBI_AW-1:ADDR_LSB]), .o_q(w_addrS));
    ppc_ebi_sync #(.W(DW), .STAGES(SYNC_STAGES), .RST_VAL({DW{1'b0}})) u_syncData (
        .clk(clk), .rst(rst), .i_d(bus.ebi_data_i), .o_q(w_dataS));

    // Output enable is tracked for completeness but plays no part in decode.
    assign w_unusedOe = w_oeNS;

    logic           w_csAny;
    logic [CSW-1:0] w_csIdx;
    logic           w_wc;
    logic           w_rc;
    logic           w_match;

    always_comb begin
        w_csIdx = '0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if (!w_csNS[i]) w_csIdx = CSW'(i);
        end
    end

    assign w_csAny = ~&w_csNS;
    assign w_wc    = ~w_rdWrS & w_csAny & (w_weNS != {BE_W{1'b1}});
    assign w_rc    =  w_rdWrS & w_csAny & (w_weNS == {BE_W{1'b1}});

    state_t              r_state, w_nextState;
    logic                r_armed;
    logic [SYNC_STAGES-1:0] r_fill;
    acc_t                r_shType;
    logic [OAW-1:0]      r_shAddr;
    logic [CSW-1:0]      r_shIdx;
    logic [BE_W-1:0]     r_shBe;
    logic [DW-1:0]       r_shData;

    assign w_match = ((r_shType == WR) ? w_wc : w_rc) &&
                     (w_addrS == r_shAddr) && (w_csIdx == r_shIdx);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (r_armed && (w_wc || w_rc)) w_nextState = QUAL;
            QUAL:    w_nextState = w_match ? ACCESS : IDLE;
            ACCESS:  w_nextState = HOLD;
            HOLD:    if (!w_csAny) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Arming waits until the synchronizers hold post-reset pin samples, so a
    // chip select held low across reset is never mistaken for a fresh cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_armed  <= 1'b0;
            r_fill   <= '0;
            r_shType <= RD;
            r_shAddr <= '0;
            r_shIdx  <= '0;
            r_shBe   <= '0;
            r_shData <= '0;
        end else begin
            r_state <= w_nextState;
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (r_fill[SYNC_STAGES-1] && !w_csAny) r_armed <= 1'b1;
            if (r_state == IDLE && w_nextState == QUAL) begin
                r_shType <= w_wc ? WR : RD;
                r_shAddr <= w_addrS;
                r_shIdx  <= w_csIdx;
                r_shBe   <= w_rc ? {BE_W{1'b1}} : ~w_weNS;
                r_shData <= w_dataS;
            end
        end
    end

    logic [OAW-1:0]  r_addrO;
    logic [CSW-1:0]  r_csIdxO;
    logic [BE_W-1:0] r_beO;
    logic [DW-1:0]   r_wdataO;
    logic            r_reO;
    logic            r_weO;
    logic [DW-1:0]   r_dataO;
    logic            r_dataOe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addrO  <= '0;
            r_csIdxO <= '0;
            r_beO    <= '0;
            r_wdataO <= '0;
            r_reO    <= 1'b0;
            r_weO    <= 1'b0;
            r_dataO  <= '0;
            r_dataOe <= 1'b0;
        end else begin
            r_reO <= 1'b0;
            r_weO <= 1'b0;
            if (r_state == QUAL && w_nextState == ACCESS) begin
                r_addrO  <= r_shAddr;
                r_csIdxO <= r_shIdx;
                r_beO    <= r_shBe;
                r_wdataO <= r_shData;
                r_weO    <= (r_shType == WR);
                r_reO    <= (r_shType == RD);
            end
            if (r_state == ACCESS && r_shType == RD) begin
                r_dataO  <= bus.rd_data_i;
                r_dataOe <= 1'b1;
            end
            if (r_state == HOLD && w_nextState == IDLE) r_dataOe <= 1'b0;
        end
    end

    assign bus.addr_o      = r_addrO;
    assign bus.cs_idx_o    = r_csIdxO;
    assign bus.be_o        = r_beO;
    assign bus.wdata_o     = r_wdataO;
    assign bus.re_o        = r_reO;
    assign bus.we_o        = r_weO;
    assign bus.ebi_data_o  = r_dataO;
    assign bus.ebi_data_oe = r_dataOe;

endmodule

// File: tb/tb_ppc_ebi_slave.sv
// Randomized self-checking bench for ppc_ebi_slave (NCS=4, two-stage sync),
// using a per-transaction timing model built from the bus-cycle rules.
module tb_ppc_ebi_slave;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    ppc_ebi_slave_if #(.NCS(4)) bus ();

    ppc_ebi_slave #(.NCS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [21:0] mAddr;
    logic [1:0]  mIdx;
    logic [3:0]  mBe;
    logic [31:0] mWdata;
    logic [31:0] mRdata;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkLatched();
        checkOutput("addr_o", 32'(bus.addr_o), 32'(mAddr));
        checkOutput("cs_idx_o", 32'(bus.cs_idx_o), 32'(mIdx));
        checkOutput("be_o", 32'(bus.be_o), 32'(mBe));
        checkOutput("wdata_o", bus.wdata_o, mWdata);
        checkOutput("ebi_data_o", bus.ebi_data_o, mRdata);
    endtask

    // One bus cycle: CS low for lowLen pin samples then high for gapLen. Called
    // just after a falling edge; relative edge n is the n-th rising edge.
    task automatic applyStimulus(input logic [3:0] cs, input logic [3:0] we, input logic rdwr,
                                 input logic [23:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdd, input int lowLen, input int gapLen,
                                 input bit scramble);
        bit         isWr, isRd, strobe;
        int         idleEdge;
        logic [1:0] idx;
        isWr     = !rdwr && (we != 4'hF);
        isRd     = rdwr && (we == 4'hF);
        strobe   = (isWr || isRd) && (lowLen >= 2);
        idleEdge = (lowLen + 2 > 5) ? lowLen + 2 : 5;
        idx      = 2'd0;
        for (int i = 3; i >= 0; i--) if (!cs[i]) idx = i[1:0];
        bus.rd_data_i = rdd;
        for (int n = 0; n < lowLen + gapLen; n++) begin
            if (n < lowLen) begin
                bus.cs_n = cs;
                if (n < 2 || !scramble || !(isWr || isRd)) begin
                    bus.we_n       = we;
                    bus.rd_wr      = rdwr;
                    bus.ebi_addr   = addr;
                    bus.ebi_data_i = wd;
                end else begin
                    bus.we_n       = 4'($urandom);
                    bus.rd_wr      = 1'($urandom_range(0, 1));
                    bus.ebi_addr   = 24'($urandom);
                    bus.ebi_data_i = $urandom;
                end
            end else begin
                bus.cs_n = 4'hF;
            end
            bus.oe_n = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (strobe && n == 3) begin
                mAddr  = addr[23:2];
                mIdx   = idx;
                mBe    = isRd ? 4'hF : ~we;
                mWdata = wd;
            end
            if (strobe && isRd && n == 4) mRdata = rdd;
            @(negedge clk);
            checkOutput("we_o", 32'(bus.we_o), 32'(strobe && isWr && n == 3));
            checkOutput("re_o", 32'(bus.re_o), 32'(strobe && isRd && n == 3));
            checkOutput("ebi_data_oe", 32'(bus.ebi_data_oe),
                        32'(strobe && isRd && n >= 4 && n < idleEdge));
        end
        checkLatched();
    endtask

    initial begin
        logic [3:0]  cs, we;
        logic        rdwr;
        testsRun       = 0;
        testsFailed    = 0;
        rst            = 1'b1;
        bus.cs_n       = 4'hF;
        bus.oe_n       = 1'b1;
        bus.we_n       = 4'hF;
        bus.rd_wr      = 1'b0;
        bus.ebi_addr   = '0;
        bus.ebi_data_i = '0;
        bus.rd_data_i  = '0;
        mAddr = '0; mIdx = '0; mBe = '0; mWdata = '0; mRdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset re_o", 32'(bus.re_o), 32'd0);
        checkOutput("reset we_o", 32'(bus.we_o), 32'd0);
        checkOutput("reset ebi_data_oe", 32'(bus.ebi_data_oe), 32'd0);
        checkLatched();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] directed write");
        applyStimulus(4'b1110, 4'b0000, 1'b0, 24'h123454, 32'hDEADBEEF, 32'h0, 8, 3, 1'b0);
        checkOutput("write addr value", 32'(bus.addr_o), 32'h048D15);

        $display("[TB] directed read");
        applyStimulus(4'b1110, 4'hF, 1'b1, 24'h00ABC8, 32'h11112222, 32'hCAFEF00D, 8, 4, 1'b0);
        checkOutput("read data value", bus.ebi_data_o, 32'hCAFEF00D);

        $display("[TB] one-clock glitch");
        applyStimulus(4'b1110, 4'b0000, 1'b0, 24'h777770, 32'h55AA55AA, 32'h0, 1, 3, 1'b0);

        $display("[TB] byte write on CS1 with long hold");
        applyStimulus(4'b1001, 4'b1101, 1'b0, 24'h0F0F0C, 32'h12345678, 32'h0, 12, 3, 1'b1);
        checkOutput("byte cs_idx", 32'(bus.cs_idx_o), 32'd1);
        checkOutput("byte be", 32'(bus.be_o), 32'h2);

        $display("[TB] reset during qualification");
        bus.cs_n = 4'b1110; bus.we_n = 4'b0000; bus.rd_wr = 1'b0;
        bus.ebi_addr = 24'hABCDE0; bus.ebi_data_i = 32'hFEEDFACE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mAddr = '0; mIdx = '0; mBe = '0; mWdata = '0; mRdata = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("post-reset we_o", 32'(bus.we_o), 32'd0);
        end
        checkLatched();
        bus.cs_n = 4'hF;
        repeat (3) @(negedge clk);
        applyStimulus(4'b1110, 4'b0000, 1'b0, 24'h135790, 32'h0BADF00D, 32'h0, 6, 3, 1'b0);

        $display("[TB] back-to-back writes");
        applyStimulus(4'b1110, 4'b0011, 1'b0, 24'h000104, 32'hA1A1A1A1, 32'h0, 8, 1, 1'b0);
        applyStimulus(4'b1110, 4'b1100, 1'b0, 24'h000208, 32'hB2B2B2B2, 32'h0, 8, 3, 1'b0);

        $display("[TB] random bus cycles");
        for (int t = 0; t < 40; t++) begin
            cs   = 4'($urandom);
            if (cs == 4'hF) cs[$urandom_range(0, 3)] = 1'b0;
            rdwr = 1'($urandom_range(0, 1));
            if (rdwr) begin
                we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end else begin
                we = 4'($urandom);
                if (we == 4'hF && $urandom_range(0, 7) != 0) we = 4'h0;
            end
            applyStimulus(cs, we, rdwr, 24'($urandom), $urandom, $urandom,
                          $urandom_range(1, 8), $urandom_range(3, 5), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
